// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transaction controller.
package spi_pkg;

    localparam int BYTE_W   = 8;
    localparam int CS_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        WAIT,
        HOLD,
        GAP
    } spi_ctrl_state_t;

endpackage

// File: rtl/spi_master_ctrl_piso.sv
// spi_piso: 8-bit parallel-load, MSB-first TX shift register feeding MOSI.
module spi_piso
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              shift_en,
    output logic              mosi
);

    logic [BYTE_W-1:0] sr_q, sr_d;

    // Next shift-register value: a load wins over a shift.
    always_comb begin
        sr_d = sr_q;
        if (load)
            sr_d = load_data;
        else if (shift_en)
            sr_d = {sr_q[BYTE_W-2:0], 1'b0};
    end

    // Shift-register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

    assign mosi = sr_q[BYTE_W-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: byte-level SPI master with CS setup/hold/idle framing,
// MSB-first serialisation, burst support and a held RX capture register.
// Optional feature macro: SPI_CTRL_RX_OVERRUN_EN (sticky rx_overrun flag).
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 1,
    parameter int CS_IDLE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              mosi,
    output logic              cs_n,
    output logic              sclk_en,
    output logic              shift_en,
    input  logic [BYTE_W-1:0] sipo_data,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              busy
);

    spi_ctrl_state_t     state_q, state_d;
    logic [CS_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                last_q, last_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                load;
    logic                accept;
    logic                capture;
    logic                piso_mosi;

    assign tx_ready = (state_q == IDLE) || (state_q == WAIT) ||
                      ((state_q == DONE) && !last_q);
    assign accept   = tx_valid && tx_ready;
    // cs_n is decoded from the state flop, so reset raises it asynchronously.
    assign cs_n     = (state_q == IDLE) || (state_q == GAP);
    assign shift_en = (state_q == SHIFT);
    assign sclk_en  = shift_en;
    assign mosi     = shift_en && piso_mosi;
    assign busy     = (state_q != IDLE);
    // sipo has taken its 8th bit by the time DONE is reached.
    assign capture  = (state_q == DONE);

    // Next-state, counter and TX load control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        load      = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                load    = 1'b1;
                last_d  = tx_last;
                cnt_d   = CS_CNT_W'(CS_SETUP);
                state_d = SETUP;
            end
            SETUP: begin
                if (cnt_q <= CS_CNT_W'(1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    cnt_d = cnt_q - CS_CNT_W'(1);
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7)
                    state_d = DONE;
            end
            DONE: begin
                if (last_q) begin
                    cnt_d   = CS_CNT_W'(CS_HOLD);
                    state_d = HOLD;
                end else if (accept) begin
                    // Burst continuation: CS is already set up, shift at once.
                    load      = 1'b1;
                    last_d    = tx_last;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: if (accept) begin
                load      = 1'b1;
                last_d    = tx_last;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            HOLD: begin
                if (cnt_q <= CS_CNT_W'(1)) begin
                    cnt_d   = CS_CNT_W'(CS_IDLE);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CS_CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q <= CS_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CS_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RX holding register: a capture always wins, otherwise a handshake drains.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (capture) begin
            rx_data_d  = sipo_data;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_CTRL_RX_OVERRUN_EN
    logic rx_overrun_q, rx_overrun_d;

    // Sticky overrun: a capture lands on a byte nobody has taken.
    always_comb begin
        rx_overrun_d = rx_overrun_q;
        if (capture && rx_valid_q && !rx_ready)
            rx_overrun_d = 1'b1;
    end

    // Overrun flag storage, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rx_overrun_q <= 1'b0;
        else
            rx_overrun_q <= rx_overrun_d;
    end

    assign rx_overrun = rx_overrun_q;
`else
    assign rx_overrun = 1'b0;
`endif

    spi_piso u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (tx_data),
        .shift_en  (shift_en),
        .mosi      (piso_mosi)
    );

endmodule
